// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared definitions for the hazard/forwarding unit of the pipelined MIPS
//   core: default widths and latencies, Tuse/Tnew encodings, pipeline stage
//   indices, and a small elaboration-time helper.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  // Default geometry.
  localparam int HS_AW       = 5;
  localparam int HS_DW       = 32;
  localparam int HS_NSTAGE   = 3;
  localparam int HS_TW       = 2;
  localparam int HS_MULT_LAT = 5;
  localparam int HS_DIV_LAT  = 10;

  // Tuse: cycles after D until the operand is consumed.
  localparam logic [HS_TW-1:0] TUSE_D = 2'd0;
  localparam logic [HS_TW-1:0] TUSE_E = 2'd1;
  localparam logic [HS_TW-1:0] TUSE_M = 2'd2;

  // Tnew: cycles after entering E until the result is on its stage WD.
  localparam logic [HS_TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [HS_TW-1:0] TNEW_LOAD = 2'd2;

  // Stage indices. Consumers are 0..NSTAGE-1, producers 1..NSTAGE.
  // Producer p drives its WD on st_wd slice [p-1].
  localparam int STG_D = 0;
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  // Larger of two latencies; sizes the MDU busy counter.
  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundle between the pipeline (master) and the hazard scoreboard (slave).
//   Pipeline -> scoreboard : flush, D-stage source/destination info, MDU start,
//                            producer WD values, unbypassed consumer operands.
//   Scoreboard -> pipeline : stall, md_busy, bypassed consumer operands.
//   Packed [NSTAGE-1:0][DW-1:0] arrays have the same layout as the flat
//   NSTAGE*DW vectors with slice [i] at bits [i*DW +: DW].
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW     = HS_AW,
  parameter int DW     = HS_DW,
  parameter int NSTAGE = HS_NSTAGE,
  parameter int TW     = HS_TW
) ();

  logic                         flush;
  logic [AW-1:0]                d_rs;
  logic [AW-1:0]                d_rt;
  logic                         d_rs_used;
  logic                         d_rt_used;
  logic [TW-1:0]                d_tuse_rs;
  logic [TW-1:0]                d_tuse_rt;
  logic                         d_wen;
  logic [AW-1:0]                d_a3;
  logic [TW-1:0]                d_tnew;
  logic                         d_is_md;
  logic                         md_start;
  logic                         md_is_div;
  logic [NSTAGE-1:0][DW-1:0]    st_wd;
  logic [NSTAGE-1:0][DW-1:0]    raw_rs;
  logic [NSTAGE-1:0][DW-1:0]    raw_rt;
  logic                         stall;
  logic                         md_busy;
  logic [NSTAGE-1:0][DW-1:0]    fwd_rs;
  logic [NSTAGE-1:0][DW-1:0]    fwd_rt;

  modport master (
    output flush, d_rs, d_rt, d_rs_used, d_rt_used, d_tuse_rs, d_tuse_rt,
           d_wen, d_a3, d_tnew, d_is_md, md_start, md_is_div,
           st_wd, raw_rs, raw_rt,
    input  stall, md_busy, fwd_rs, fwd_rt
  );

  modport slave (
    input  flush, d_rs, d_rt, d_rs_used, d_rt_used, d_tuse_rs, d_tuse_rt,
           d_wen, d_a3, d_tnew, d_is_md, md_start, md_is_div,
           st_wd, raw_rs, raw_rt,
    output stall, md_busy, fwd_rs, fwd_rt
  );

endinterface : hazard_scoreboard_if

// File: rtl/hazard_scoreboard_hs_fwd_mux.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_hs_fwd_mux
//   Bypass select for one source operand of consumer stage C. Scans producer
//   entries C+1..NSTAGE; the youngest (smallest p) matching entry wins. A ready
//   match (tnew==0) forwards that producer's WD, otherwise the raw operand
//   passes through.
//   Ports:
//     src_i/used_i          source register address and its read-enable
//     ent_*_i               scoreboard entries, index 1..NSTAGE
//     st_wd_i               producer WD values, producer p at slice [p-1]
//     raw_i                 unbypassed operand held by consumer C
//     fwd_o                 bypassed operand
//     hit_o/hit_tnew_o      youngest match flag and its remaining Tnew
// -----------------------------------------------------------------------------
module hazard_scoreboard_hs_fwd_mux
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW     = HS_AW,
  parameter int DW     = HS_DW,
  parameter int NSTAGE = HS_NSTAGE,
  parameter int TW     = HS_TW,
  parameter int C      = STG_D
) (
  input  logic [AW-1:0]              src_i,
  input  logic                       used_i,
  input  logic [NSTAGE:1]            ent_valid_i,
  input  logic [NSTAGE:1][AW-1:0]    ent_a3_i,
  input  logic [NSTAGE:1][TW-1:0]    ent_tnew_i,
  input  logic [NSTAGE-1:0][DW-1:0]  st_wd_i,
  input  logic [DW-1:0]              raw_i,
  output logic [DW-1:0]              fwd_o,
  output logic                       hit_o,
  output logic [TW-1:0]              hit_tnew_o
);

  always_comb begin
    // NOTE: every output gets a default before the scan so no path through
    // the block leaves a value unassigned, which would infer a latch.
    fwd_o      = raw_i;
    hit_o      = 1'b0;
    hit_tnew_o = '0;
    // Oldest to youngest: a later (younger) hit overwrites an older one.
    for (int p = NSTAGE; p > C; p--) begin
      if (used_i && (src_i != '0) && ent_valid_i[p] && (ent_a3_i[p] == src_i)) begin
        hit_o      = 1'b1;
        hit_tnew_o = ent_tnew_i[p];
        fwd_o      = (ent_tnew_i[p] == '0) ? st_wd_i[p-1] : raw_i;
      end
    end
  end

endmodule : hazard_scoreboard_hs_fwd_mux

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard/forwarding unit for the pipelined MIPS core. Keeps a stage-tagged
//   record of in-flight GRF writes (dest, remaining Tnew) plus the source
//   addresses of instructions in E..stage NSTAGE-1, raises the D-stage stall
//   from Tuse/Tnew and MDU occupancy, and bypasses operands for every consumer.
//   Ports:
//     clk, reset   clock; synchronous active-high reset
//     bus          hazard_scoreboard_if.slave (pipeline handshake bundle)
//   Requires NSTAGE >= 2.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW       = HS_AW,
  parameter int DW       = HS_DW,
  parameter int NSTAGE   = HS_NSTAGE,
  parameter int TW       = HS_TW,
  parameter int MULT_LAT = HS_MULT_LAT,
  parameter int DIV_LAT  = HS_DIV_LAT
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int CW = $clog2(lat_max(MULT_LAT, DIV_LAT) + 1);

  // Producer entries, index = stage (1=E .. NSTAGE).
  logic [NSTAGE:1]           ent_valid_q, ent_valid_d;
  logic [NSTAGE:1][AW-1:0]   ent_a3_q,    ent_a3_d;
  logic [NSTAGE:1][TW-1:0]   ent_tnew_q,  ent_tnew_d;

  // Consumer source pipe, index = stage (1=E .. NSTAGE-1).
  logic [NSTAGE-1:1]         rs_used_q, rs_used_d;
  logic [NSTAGE-1:1]         rt_used_q, rt_used_d;
  logic [NSTAGE-1:1][AW-1:0] rs_q, rs_d;
  logic [NSTAGE-1:1][AW-1:0] rt_q, rt_d;

  logic [CW-1:0]             md_cnt_q, md_cnt_d;

  logic                      stall;
  logic                      md_busy;

  logic [NSTAGE-1:0][DW-1:0] fwd_rs_w, fwd_rt_w;
  logic [NSTAGE-1:0]         rs_hit, rt_hit;
  logic [NSTAGE-1:0][TW-1:0] rs_hit_tnew, rt_hit_tnew;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ent_valid_d = '0;
    ent_a3_d    = '0;
    ent_tnew_d  = '0;
    rs_used_d   = '0;
    rt_used_d   = '0;
    rs_d        = '0;
    rt_d        = '0;

    // A stalled D injects a bubble; $0 writes never occupy an entry.
    ent_valid_d[1] = ~stall & bus.d_wen & (bus.d_a3 != '0);
    ent_a3_d[1]    = bus.d_a3;
    ent_tnew_d[1]  = bus.d_tnew;
    for (int p = 2; p <= NSTAGE; p++) begin
      ent_valid_d[p] = ent_valid_q[p-1];
      ent_a3_d[p]    = ent_a3_q[p-1];
      ent_tnew_d[p]  = (ent_tnew_q[p-1] == '0) ? '0 : ent_tnew_q[p-1] - TW'(1);
    end

    rs_d[1]      = bus.d_rs;
    rt_d[1]      = bus.d_rt;
    rs_used_d[1] = ~stall & bus.d_rs_used;
    rt_used_d[1] = ~stall & bus.d_rt_used;
    for (int c = 2; c < NSTAGE; c++) begin
      rs_d[c]      = rs_q[c-1];
      rt_d[c]      = rt_q[c-1];
      rs_used_d[c] = rs_used_q[c-1];
      rt_used_d[c] = rt_used_q[c-1];
    end

    // Flush overrides the shift; it leaves the MDU alone.
    if (bus.flush) begin
      ent_valid_d = '0;
      rs_used_d   = '0;
      rt_used_d   = '0;
    end

    if (bus.md_start) begin
      md_cnt_d = bus.md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (reset) begin
      ent_valid_q <= '0;
      rs_used_q   <= '0;
      rt_used_q   <= '0;
      md_cnt_q    <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      rs_used_q   <= rs_used_d;
      rt_used_q   <= rt_used_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  // NOTE: address and Tnew fields are left unreset on purpose; they are only
  // looked at when the matching valid/used bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    ent_a3_q   <= ent_a3_d;
    ent_tnew_q <= ent_tnew_d;
    rs_q       <= rs_d;
    rt_q       <= rt_d;
  end

  // ---------------------------------------------------------------------------
  // Per-consumer bypass selects
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NSTAGE; c++) begin : g_cons
    logic [AW-1:0] rs_src, rt_src;
    logic          rs_use, rt_use;

    if (c == STG_D) begin : g_dsrc
      assign rs_src = bus.d_rs;
      assign rt_src = bus.d_rt;
      assign rs_use = bus.d_rs_used;
      assign rt_use = bus.d_rt_used;
    end else begin : g_psrc
      assign rs_src = rs_q[c];
      assign rt_src = rt_q[c];
      assign rs_use = rs_used_q[c];
      assign rt_use = rt_used_q[c];
    end

    hazard_scoreboard_hs_fwd_mux #(
      .AW(AW), .DW(DW), .NSTAGE(NSTAGE), .TW(TW), .C(c)
    ) u_rs (
      .src_i       (rs_src),
      .used_i      (rs_use),
      .ent_valid_i (ent_valid_q),
      .ent_a3_i    (ent_a3_q),
      .ent_tnew_i  (ent_tnew_q),
      .st_wd_i     (bus.st_wd),
      .raw_i       (bus.raw_rs[c]),
      .fwd_o       (fwd_rs_w[c]),
      .hit_o       (rs_hit[c]),
      .hit_tnew_o  (rs_hit_tnew[c])
    );

    hazard_scoreboard_hs_fwd_mux #(
      .AW(AW), .DW(DW), .NSTAGE(NSTAGE), .TW(TW), .C(c)
    ) u_rt (
      .src_i       (rt_src),
      .used_i      (rt_use),
      .ent_valid_i (ent_valid_q),
      .ent_a3_i    (ent_a3_q),
      .ent_tnew_i  (ent_tnew_q),
      .st_wd_i     (bus.st_wd),
      .raw_i       (bus.raw_rt[c]),
      .fwd_o       (fwd_rt_w[c]),
      .hit_o       (rt_hit[c]),
      .hit_tnew_o  (rt_hit_tnew[c])
    );
  end

  // Only the D-stage match information feeds the stall.
  logic unused_side;
  assign unused_side = ^{rs_hit[NSTAGE-1:1], rt_hit[NSTAGE-1:1],
                         rs_hit_tnew[NSTAGE-1:1], rt_hit_tnew[NSTAGE-1:1]};

  // ---------------------------------------------------------------------------
  // Stall / MDU busy
  // ---------------------------------------------------------------------------
  assign md_busy = (md_cnt_q != '0);

  // A producer whose result is further away than the consumer's Tuse cannot
  // be bypassed in time. md_start covers the cycle before the counter loads.
  assign stall = (rs_hit[STG_D] && (rs_hit_tnew[STG_D] > bus.d_tuse_rs)) ||
                 (rt_hit[STG_D] && (rt_hit_tnew[STG_D] > bus.d_tuse_rt)) ||
                 (bus.d_is_md && (md_busy || bus.md_start));

  assign bus.stall   = stall;
  assign bus.md_busy = md_busy;
  assign bus.fwd_rs  = fwd_rs_w;
  assign bus.fwd_rt  = fwd_rt_w;

  a_md_start_idle : assert property (@(posedge clk) disable iff (reset)
                                     !(bus.md_start && md_busy));

endmodule : hazard_scoreboard
